activation_lut_sequencer: RTL and testbench
===========================================

ACTIVATION_LUT_SEQUENCER -- requirements
Module: activation_lut_sequencer

Interface
REQ-001 Parameter WIDTH, 8, data width of input sample, table entries and outputs (signed two's complement).
REQ-002 Parameter FRAC, 4, fractional bits of input sample; table has 2**(WIDTH-FRAC)=16 entries.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tbl_we  in  1  table write strobe.
REQ-006 tbl_addr  in  4  table write address (0..15).
REQ-007 tbl_wdata  in  signed 8  table write data.
REQ-008 in_valid  in  1  input sample valid.
REQ-009 in_ready  out  1  block accepts sample this cycle.
REQ-010 in_data  in  signed 8  input sample, Q4.4.
REQ-011 out_valid  out  1  output triple valid.
REQ-012 out_ready  in  1  downstream interpolator accepts triple.
REQ-013 out_base  out  signed 8  table value at sample segment start.
REQ-014 out_next  out  signed 8  table value at next segment point.
REQ-015 out_remaining  out  signed 8  fractional offset within segment, range 0..15.

Function
REQ-016 Table: 16 x 8-bit register array; write when tbl_we=1, any cycle, independent of handshakes.
REQ-017 Segment address addr = signed(in_data[7:4]) + 8, range 0..15 (in_data=0x80 -> 0, 0x7F -> 15).
REQ-018 out_base = table[addr]; out_next = table[addr+1] for addr<15, table[15] for addr=15 (clamp, no wrap to 0).
REQ-019 out_remaining = {4'b0000, in_data[3:0]}, always non-negative.
REQ-020 Input handshake: transfer when in_valid=1 and in_ready=1; output handshake: transfer when out_valid=1 and out_ready=1.
REQ-021 Two-stage pipeline: stage S1 registers sample and addr; stage S2 registers base/next/remaining and drives outputs.
REQ-022 Latency: sample accepted in cycle N appears with out_valid=1 in cycle N+2 when not stalled.
REQ-023 S2 loads from S1 when S1 full and (S2 empty or out_ready=1); table read for S2 load uses pre-write contents if tbl_we targets same entry that cycle.
REQ-024 in_ready = not (S1 full and S2 full and out_ready=0); combinational, throughput one sample per cycle.
REQ-025 S2 outputs held stable while out_valid=1 and out_ready=0.
REQ-026 Samples leave in acceptance order; none dropped or duplicated.
REQ-027 out_base/out_next/out_remaining hold last transferred values when out_valid=0.

Reset
REQ-028 On rst=1: S1, S2 emptied; out_valid=0; out_base, out_next, out_remaining=0; all 16 table entries=0.
REQ-029 in_ready=1 in the first cycle after rst deasserts.
REQ-030 rst mid-operation discards in-flight samples; tbl_we and in_valid ignored while rst=1.

Verification
REQ-031 Load table[i]=8*i-64; in_data=0x13, out_ready=1 -> 2 cycles later out_valid=1, base=8, next=16, remaining=3.
REQ-032 Same table; in_data=0x7F -> base=56, next=56, remaining=15; in_data=0x80 -> base=-64, next=-56, remaining=0.
REQ-033 out_ready=0, in_valid=1 for 3 samples 0x00,0x10,0x20 -> first two accepted, in_ready=0 on third; out_ready=1 -> triples out in order with bases 0,8,16.
REQ-034 Sample in S1 with addr 9 and tbl_we to entry 9 (value 100) in the S2-load cycle -> out_base=8; next sample with addr 9 -> out_base=100.
REQ-035 Streaming 16 back-to-back samples, out_ready=1 -> 16 consecutive out_valid cycles, no bubbles.
REQ-036 rst=1 with both stages full -> next cycle out_valid=0, all outputs 0, table reads 0 for any addr.

Source files
------------

// File: rtl/activation_lut_sequencer.sv
// Activation-function lookup sequencer.
// Maps a signed Q(WIDTH-FRAC).FRAC sample onto a 2**(WIDTH-FRAC)-entry
// table and emits {segment base, next point, fractional remainder} for a
// downstream linear interpolator through a two-stage valid/ready pipeline.
module activation_lut_sequencer #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tbl_we,
    input  logic [WIDTH-FRAC-1:0]         tbl_addr,
    input  logic signed [WIDTH-1:0]       tbl_wdata,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WIDTH-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH-1:0]       out_base,
    output logic signed [WIDTH-1:0]       out_next,
    output logic signed [WIDTH-1:0]       out_remaining
);

    localparam int               ABITS = WIDTH - FRAC;
    localparam int unsigned      DEPTH = 1 << ABITS;
    localparam logic [ABITS-1:0] LAST  = '1;

    // Lookup table storage
    logic signed [WIDTH-1:0] lut [DEPTH];

    // Stage 1: accepted sample, already reduced to segment address + fraction
    logic                    s1_full;
    logic [ABITS-1:0]        s1_addr;
    logic [FRAC-1:0]         s1_frac;

    // Stage 2 occupancy; the output data registers are the stage-2 payload
    logic                    s2_full;

    logic                    accept;
    logic                    s2_load;
    logic                    s2_drain;
    logic [ABITS-1:0]        in_addr;
    logic [ABITS-1:0]        next_addr;
    logic signed [WIDTH-1:0] rd_base;
    logic signed [WIDTH-1:0] rd_next;
    logic signed [WIDTH-1:0] rd_rem;

    // Handshake decisions, segment addressing and table read for the S2 load
    always_comb begin
        s2_load   = s1_full && (!s2_full || out_ready);
        s2_drain  = s2_full && out_ready;
        // S1 is free either because it is empty or because it moves into S2 now
        in_ready  = !s1_full || s2_load;
        accept    = in_valid && in_ready;
        out_valid = s2_full;

        // signed integer part + DEPTH/2 is the integer part with its MSB inverted
        in_addr   = {~in_data[WIDTH-1], in_data[WIDTH-2:FRAC]};

        // Top segment has no successor: clamp instead of wrapping to entry 0
        next_addr = (s1_addr == LAST) ? LAST : s1_addr + ABITS'(1);

        rd_base   = lut[s1_addr];
        rd_next   = lut[next_addr];
        rd_rem    = {{(WIDTH-FRAC){1'b0}}, s1_frac};
    end

    // Table writes; independent of the data pipeline, blocked during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lut <= '{default: '0};
        end else if (tbl_we) begin
            lut[tbl_addr] <= tbl_wdata;
        end
    end

    // Stage 1: capture accepted samples, release when S2 takes them
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full <= 1'b0;
            s1_addr <= '0;
            s1_frac <= '0;
        end else if (accept) begin
            s1_full <= 1'b1;
            s1_addr <= in_addr;
            s1_frac <= in_data[FRAC-1:0];
        end else if (s2_load) begin
            s1_full <= 1'b0;
        end
    end

    // Stage 2: load the triple from S1 (table read sees pre-write contents),
    // hold it while stalled, keep last values after it drains
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_full       <= 1'b0;
            out_base      <= '0;
            out_next      <= '0;
            out_remaining <= '0;
        end else if (s2_load) begin
            s2_full       <= 1'b1;
            out_base      <= rd_base;
            out_next      <= rd_next;
            out_remaining <= rd_rem;
        end else if (s2_drain) begin
            s2_full       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_activation_lut_sequencer.sv
// Self-checking bench for activation_lut_sequencer: directed vector table,
// multi-cycle corner sequences and a randomized run against a queue model.
module tb_activation_lut_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic              tbl_we;
    logic [3:0]        tbl_addr;
    logic signed [7:0] tbl_wdata;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_base;
    logic signed [7:0] out_next;
    logic signed [7:0] out_remaining;

    int checks   = 0;
    int failures = 0;

    // Reference table contents as the bench believes them to be
    int mtab [16];

    typedef struct {
        logic [7:0] din;
        int         base;
        int         nxt;
        int         rem;
    } vec_t;

    typedef struct {
        int b;
        int n;
        int r;
    } trip_t;

    vec_t  vecs [8];
    trip_t q [$];

    activation_lut_sequencer #(.WIDTH(8), .FRAC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_base      (out_base),
        .out_next      (out_next),
        .out_remaining (out_remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected triple from the table rules: segment = signed integer part + 8
    function automatic trip_t model(input logic [7:0] d);
        trip_t      t;
        logic [3:0] hi;
        logic [3:0] lo;
        int         a;
        hi  = d[7:4];
        lo  = d[3:0];
        a   = int'($signed(hi)) + 8;
        t.b = mtab[a];
        t.n = (a == 15) ? mtab[15] : mtab[a + 1];
        t.r = int'(lo);
        return t;
    endfunction

    task automatic wr(input int a, input int v);
        tbl_we    = 1'b1;
        tbl_addr  = 4'(a);
        tbl_wdata = 8'(v);
        tick();
        tbl_we    = 1'b0;
        mtab[a]   = v;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) wr(i, 8 * i - 64);
    endtask

    // Single sample on an idle pipeline with out_ready=1: checks 2-cycle latency
    task automatic send_one(input string name, input logic [7:0] d,
                            input int eb, input int en, input int er);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        @(negedge clk);
        check({name, "_in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_valid_n1"}, int'(out_valid), 0);
        tick();
        @(negedge clk);
        check({name, "_valid_n2"}, int'(out_valid), 1);
        check({name, "_base"}, int'(out_base), eb);
        check({name, "_next"}, int'(out_next), en);
        check({name, "_rem"}, int'(out_remaining), er);
        tick();
        @(negedge clk);
        check({name, "_valid_after"}, int'(out_valid), 0);
        tick();
    endtask

    initial begin
        int         got;
        int         nv;
        int         first;
        int         last;
        int         sidx;
        int         bp_exp [3];
        logic [7:0] sdat [16];
        logic [3:0] n4;
        trip_t      t;
        trip_t      e;

        vecs[0] = '{din: 8'h13, base:   8, nxt:  16, rem:  3};
        vecs[1] = '{din: 8'h7F, base:  56, nxt:  56, rem: 15};
        vecs[2] = '{din: 8'h80, base: -64, nxt: -56, rem:  0};
        vecs[3] = '{din: 8'h00, base:   0, nxt:   8, rem:  0};
        vecs[4] = '{din: 8'hF5, base:  -8, nxt:   0, rem:  5};
        vecs[5] = '{din: 8'h6A, base:  48, nxt:  56, rem: 10};
        vecs[6] = '{din: 8'h9C, base: -56, nxt: -48, rem: 12};
        vecs[7] = '{din: 8'h4E, base:  32, nxt:  40, rem: 14};
        bp_exp  = '{0, 8, 16};

        for (int i = 0; i < 16; i++) mtab[i] = 0;

        rst       = 1'b1;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_base", int'(out_base), 0);
        check("rst_next", int'(out_next), 0);
        check("rst_rem", int'(out_remaining), 0);
        tick();

        // Directed vectors on ramp table[i] = 8*i-64
        load_ramp();
        for (int i = 0; i < 8; i++)
            send_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].base, vecs[i].nxt, vecs[i].rem);
        @(negedge clk);
        check("hold_base", int'(out_base), vecs[7].base);
        check("hold_rem", int'(out_remaining), vecs[7].rem);
        tick();

        // Table write to the entry being read in the S2-load cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h13;
        @(negedge clk);
        check("wr_race_in_ready", int'(in_ready), 1);
        tick();
        in_valid  = 1'b0;
        tbl_we    = 1'b1;
        tbl_addr  = 4'd9;
        tbl_wdata = 8'sd100;
        tick();
        tbl_we  = 1'b0;
        mtab[9] = 100;
        @(negedge clk);
        check("wr_race_valid", int'(out_valid), 1);
        check("wr_race_base_old", int'(out_base), 8);
        check("wr_race_next", int'(out_next), 16);
        tick();
        send_one("wr_race_new", 8'h15, 100, 16, 5);
        wr(9, 8);

        // Backpressure: two samples fill the pipe, third stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        @(negedge clk);
        check("bp_rdy0", int'(in_ready), 1);
        tick();
        in_data = 8'h10;
        @(negedge clk);
        check("bp_rdy1", int'(in_ready), 1);
        tick();
        in_data = 8'h20;
        @(negedge clk);
        check("bp_rdy2_low", int'(in_ready), 0);
        tick();
        @(negedge clk);
        check("bp_stall_valid", int'(out_valid), 1);
        check("bp_stall_base", int'(out_base), 0);
        check("bp_stall_rdy", int'(in_ready), 0);
        tick();
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (got < 3) check($sformatf("bp_order%0d", got), int'(out_base), bp_exp[got]);
                else check("bp_extra_valid", int'(out_valid), 0);
                got++;
            end
            if (in_valid && in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("bp_count", got, 3);

        // Back-to-back streaming, 16 samples
        out_ready = 1'b1;
        nv = 0; first = -1; last = -1; sidx = 0;
        for (int k = 0; k < 22; k++) begin
            if (k < 16) begin
                n4       = 4'(k);
                sdat[k]  = {n4, n4};
                in_valid = 1'b1;
                in_data  = sdat[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 16) check($sformatf("stream_rdy%0d", k), int'(in_ready), 1);
            if (out_valid) begin
                if (first < 0) first = k;
                last = k;
                nv++;
                if (sidx < 16) begin
                    e = model(sdat[sidx]);
                    check($sformatf("stream_base%0d", sidx), int'(out_base), e.b);
                    check($sformatf("stream_next%0d", sidx), int'(out_next), e.n);
                    check($sformatf("stream_rem%0d", sidx), int'(out_remaining), e.r);
                end
                sidx++;
            end
            tick();
        end
        check("stream_count", nv, 16);
        check("stream_first", first, 2);
        check("stream_last", last, 17);

        // Randomized run against the queue model, random table contents
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, int'($signed(8'($urandom))));
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            check("rnd_in_ready", int'(in_ready), int'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 0) check("rnd_idle_valid", int'(out_valid), 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 1, 0);
                end else begin
                    t = q.pop_front();
                    check("rnd_base", int'(out_base), t.b);
                    check("rnd_next", int'(out_next), t.n);
                    check("rnd_rem", int'(out_remaining), t.r);
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_data));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                t = q.pop_front();
                check("drain_base", int'(out_base), t.b);
                check("drain_next", int'(out_next), t.n);
                check("drain_rem", int'(out_remaining), t.r);
            end
            tick();
        end
        check("drain_empty", q.size(), 0);

        // Reset with both stages full; writes and inputs ignored during reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h13;
        tick();
        in_data = 8'h7F;
        tick();
        in_data = 8'h20;
        @(negedge clk);
        check("full_valid", int'(out_valid), 1);
        check("full_rdy", int'(in_ready), 0);
        tick();
        rst       = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = 4'd9;
        tbl_wdata = 8'sd55;
        tick();
        @(negedge clk);
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_base", int'(out_base), 0);
        check("mrst_next", int'(out_next), 0);
        check("mrst_rem", int'(out_remaining), 0);
        tick();
        rst      = 1'b0;
        tbl_we   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) mtab[i] = 0;
        @(negedge clk);
        check("mrst_first_rdy", int'(in_ready), 1);
        check("mrst_idle_valid0", int'(out_valid), 0);
        tick();
        @(negedge clk);
        check("mrst_idle_valid1", int'(out_valid), 0);
        tick();
        @(negedge clk);
        check("mrst_idle_valid2", int'(out_valid), 0);
        tick();
        send_one("mrst_tbl9", 8'h13, 0, 0, 3);
        send_one("mrst_tbl15", 8'h7F, 0, 0, 15);
        send_one("mrst_tbl0", 8'h80, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
